// File: rtl/led_mode_controller.sv
// Board bring-up LED arbiter: button synchroniser and debouncer, a mode FSM stepped by
// debounced presses, and a shared tick prescaler that paces the SHIFT/BLINK/COUNT animations.
module led_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       press_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_SW    = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  logic            btn_s1_q, btn_s2_q;
  logic            btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  mode_e           state_q, state_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]      led_q, led_d;
  logic [3:0]      pattern_q, pattern_d;
  logic [3:0]      count_q, count_d;
  logic            blink_off_q, blink_off_d;
  logic            tick;

  // A press is the edge on which the debounced level accepts a 0->1 change.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    press_d  = 1'b0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s2_q;
        press_d  = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign tick = (tick_cnt_q == TK_LAST);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    led_d       = led_q;
    pattern_d   = pattern_q;
    count_d     = count_q;
    blink_off_d = blink_off_q;
    if (press_d) begin
      // Mode change restarts the prescaler and discards any coincident tick.
      tick_cnt_d = '0;
      case (state_q)
        MODE_SW: begin
          state_d = MODE_SHIFT;
          led_d   = 4'b0001;
        end
        MODE_SHIFT: begin
          state_d     = MODE_BLINK;
          pattern_d   = sw;
          led_d       = sw;
          blink_off_d = 1'b0;
        end
        MODE_BLINK: begin
          state_d = MODE_COUNT;
          count_d = 4'd0;
          led_d   = 4'd0;
        end
        default: begin
          state_d = MODE_SW;
          led_d   = sw;
        end
      endcase
    end else begin
      case (state_q)
        MODE_SW: led_d = sw;
        MODE_SHIFT: if (tick) led_d = {led_q[2:0], led_q[3]};
        MODE_BLINK: if (tick) begin
          blink_off_d = ~blink_off_q;
          led_d       = blink_off_q ? pattern_q : 4'd0;
        end
        default: if (tick) begin
          count_d = count_q + 4'd1;
          led_d   = count_q + 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      state_q     <= MODE_SW;
      tick_cnt_q  <= '0;
      led_q       <= 4'd0;
      pattern_q   <= 4'd0;
      count_q     <= 4'd0;
      blink_off_q <= 1'b0;
    end else begin
      btn_s1_q    <= btn;
      btn_s2_q    <= btn_s1_q;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      led_q       <= led_d;
      pattern_q   <= pattern_d;
      count_q     <= count_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign led         = led_q;
  assign mode        = state_q;
  assign press_pulse = press_q;

endmodule

// File: doc/led_mode_controller.md
Name: led_mode_controller

Overview:
- Board bring-up controller that owns the 4 user LEDs and arbitrates them between four display sources: live switches, walking-one, blink of a latched switch value, and a binary counter.
- Synchronises and debounces the push button. Each debounced press advances the display mode.
- A shared tick prescaler paces the animated modes.
- Sits directly between the board I/O pins (clk, sw, btn) and the LED pins.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be >= 2.
- TICK_CYCLES, 12500000: clock cycles per animation tick (0.25 s at 50 MHz); must be >= 2.

Ports:
- clk  input  1  board clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw  input  4  user switches SW[3:0]; treated as quasi-static, not synchronised
- btn  input  1  raw push button, asynchronous, active-high, bouncy
- led  output  4  registered LED drive LED[3:0]
- mode  output  2  registered current mode: 0=SW, 1=SHIFT, 2=BLINK, 3=COUNT
- press_pulse  output  1  registered one-cycle strobe per accepted press

Behaviour:
- Reset (rst high at an edge) clears everything to 0: led=0000, mode=0, press_pulse=0, synchroniser flops, debounced level, debounce counter, tick prescaler, pattern and count registers. Reset overrides all other events, including mid-operation.
- Synchroniser: btn passes through two flops (btn_s1, btn_s2).
- Debounce:
  - Counter increments on every edge where btn_s2 != btn_db.
  - Counter clears on any edge where btn_s2 == btn_db.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, btn_db takes btn_s2 and the counter clears.
- Press detection:
  - On the edge where btn_db goes 0->1, press_pulse=1 for exactly one cycle and mode advances in the same edge.
  - A release (1->0) produces no pulse.
  - Latency: if btn is first sampled high at edge k and stays high, press_pulse and the new mode are visible after edge k+DEBOUNCE_CYCLES+1.
- Mode FSM: SW -> SHIFT -> BLINK -> COUNT -> SW on each press_pulse.
- Tick prescaler:
  - Free-running counter 0..TICK_CYCLES-1 generating an internal tick on its terminal count.
  - Restarts at 0 on every mode change, so the first tick of a mode occurs TICK_CYCLES edges after entry.
  - If a press and a tick coincide, the mode change wins and that tick is discarded.
- SW mode: led <= sw every edge (one-cycle latency).
- SHIFT mode:
  - On entry, led=0001.
  - Each tick rotates left: 0001->0010->0100->1000->0001.
- BLINK mode:
  - On the entering edge, the pattern register captures the sw value present at that edge, and led=pattern.
  - Each tick toggles led between pattern and 0000.
  - Later sw changes are ignored until the mode is re-entered.
- COUNT mode:
  - On entry, count=0 and led=0000.
  - Each tick increments count mod 16; led=count, so 1111 wraps to 0000.
- Exit: leaving any mode takes the new mode's entry value on the same edge. For example, COUNT->SW gives led=sw at that edge.
- Button held high through reset: after reset btn_db=0, so a press is accepted DEBOUNCE_CYCLES+2 edges after reset deasserts, the synchroniser being refilled first.

Test Plan (DEBOUNCE_CYCLES=4, TICK_CYCLES=3):
1. Reset, sw=1010 -> during reset led=0000, mode=0, press_pulse=0; first edge after reset led=1010; sw=0101 -> led=0101 next edge.
2. Bounce: btn high 3 cycles, low 2, high 2, low -> no press_pulse, mode stays 0. Then btn high 10 cycles from edge k -> single press_pulse after edge k+5, mode=1, led=0001; releasing gives no further pulse.
3. SHIFT: from entry, led reads 0001, then 0010, 0100, 1000, 0001 after 3, 6, 9 and 12 edges respectively.
4. BLINK: sw=0110 at the entering press -> led=0110, 0000 after 3 edges, 0110 after 6; sw changed to 1111 mid-mode -> pattern stays 0110.
5. COUNT: led=0000 on entry, +1 every 3 edges, reaches 1111 after 45 edges and 0000 after 48. A press coinciding with a tick -> mode=0, led=sw, no count increment.
6. Reset pulsed mid-COUNT with btn held high -> led=0000, mode=0 on that edge. With btn still high, press_pulse occurs 6 edges after rst deasserts and mode=1.
